// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - valid/ready handshake bundle for the pipe_stage_reg input and output sides
interface pipe_stage_reg_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - skid-buffered pipeline register with flush; stall/flush counters under PIPE_STAGE_PERF_EN
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             startin,
    input  logic             flush,
    pipe_stage_reg_if.slave  bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              accept;
    logic              consume;

    // Handshake outputs decode the state register only, so in_ready never depends on out_ready.
    assign bus.out_valid = (state != EMPTY);
    assign bus.in_ready  = (state != FULL);
    assign bus.out_data  = main_q;

    assign accept  = bus.in_valid & bus.in_ready;
    assign consume = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (startin) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state  <= ONE;
                        main_q <= bus.in_data;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        main_q <= bus.in_data;
                    end else if (consume) begin
                        // main keeps its last value after draining
                        state <= EMPTY;
                    end else if (accept) begin
                        state  <= FULL;
                        skid_q <= bus.in_data;
                    end
                end
                FULL: begin
                    if (consume) begin
                        state  <= ONE;
                        main_q <= skid_q;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    always_ff @(posedge clk) begin
        if (startin) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (bus.out_valid && !bus.out_ready && !flush && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush && bus.out_valid && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed scoreboard bench for pipe_stage_reg
module tb_pipe_stage_reg;
    localparam int DATA_W = 64;
    localparam int CNT_W  = 4;

    logic             clk = 1'b0;
    logic             startin;
    logic             flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    pipe_stage_reg_if #(.DATA_W(DATA_W)) bus ();

    pipe_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .startin   (startin),
        .flush     (flush),
        .bus       (bus.slave),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] last_data = '0;
    int                exp_stall = 0;
    int                exp_flush = 0;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic iv, input logic [DATA_W-1:0] d, input logic ordy,
                         input logic fl, input logic rs);
        logic acc, con, stall_hit, flush_hit;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        flush         = fl;
        startin       = rs;
        acc       = iv && (q.size() < 2);
        con       = (q.size() > 0) && ordy;
        stall_hit = (q.size() > 0) && !ordy && !fl && !rs;
        flush_hit = fl && (q.size() > 0) && !rs;
        @(posedge clk);
        #1;
        if (rs) begin
            q.delete();
            last_data = '0;
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            if (fl) begin
                q.delete();
                last_data = '0;
            end else begin
                if (con) last_data = q.pop_front();
                if (acc) q.push_back(d);
            end
`ifdef PIPE_STAGE_PERF_EN
            if (stall_hit && exp_stall < 15) exp_stall++;
            if (flush_hit && exp_flush < 15) exp_flush++;
`else
            if (stall_hit || flush_hit) begin
                exp_stall = 0;
                exp_flush = 0;
            end
`endif
        end
        chk("out_valid", DATA_W'(bus.out_valid), DATA_W'(q.size() > 0));
        chk("in_ready",  DATA_W'(bus.in_ready),  DATA_W'(q.size() < 2));
        chk("out_data",  bus.out_data, (q.size() > 0) ? q[0] : last_data);
        chk("stall_cnt", DATA_W'(stall_cnt), DATA_W'(exp_stall));
        chk("flush_cnt", DATA_W'(flush_cnt), DATA_W'(exp_flush));
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
        startin       = 1'b1;

        // reset state
        cycle(0, 64'h0, 0, 0, 1);

        // streaming 1..4 with downstream always ready
        for (int i = 1; i <= 4; i++) cycle(1, 64'(i), 1, 0, 0);
        cycle(0, 64'h0, 1, 0, 0);
        cycle(0, 64'h0, 1, 0, 0);

        // skid fill, refused third entry, then drain and late accept
        cycle(1, 64'hA, 0, 0, 0);
        cycle(1, 64'hB, 0, 0, 0);
        cycle(1, 64'hC, 0, 0, 0);
        cycle(1, 64'hC, 1, 0, 0);
        cycle(1, 64'hC, 1, 0, 0);
        cycle(0, 64'h0, 1, 0, 0);
        cycle(0, 64'h0, 1, 0, 0);

        // flush while full discards the offered entry
        cycle(1, 64'hE, 0, 0, 0);
        cycle(1, 64'hF, 0, 0, 0);
        cycle(1, 64'hD, 0, 1, 0);
        cycle(0, 64'h0, 1, 0, 0);

        // reset takes priority over flush in ONE
        cycle(1, 64'h11, 0, 0, 0);
        cycle(1, 64'h22, 1, 1, 1);

        // stall counter saturation
        cycle(1, 64'h33, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle(0, 64'h0, 0, 0, 0);
        cycle(0, 64'h0, 1, 0, 0);

        // randomized traffic against the queue model
        cycle(0, 64'h0, 0, 0, 1);
        for (int i = 0; i < 60; i++)
            cycle(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 15) == 0), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameters SHALL be: DATA_W, default 64, payload width in bits.
REQ-002 Parameters SHALL also include CNT_W, default 16, performance counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 startin  input  1  reset; synchronous, active-high.
REQ-005 flush  input  1  discard all held entries; the stage becomes a bubble.
REQ-006 in_valid  input  1  upstream offers in_data this cycle.
REQ-007 in_data  input  DATA_W  upstream payload.
REQ-008 in_ready  output  1  stage accepts in_data this cycle.
REQ-009 out_valid  output  1  out_data holds a valid entry.
REQ-010 out_data  output  DATA_W  downstream payload.
REQ-011 out_ready  input  1  downstream consumes out_data this cycle.
REQ-012 stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.
REQ-013 flush_cnt  output  CNT_W  flush cycles that discarded at least one valid entry.

Function
REQ-014 Storage SHALL be a main register (drives out_data) plus one skid register; states EMPTY, ONE (main valid), FULL (main+skid valid).
REQ-015 Transfers: accept = in_valid & in_ready; consume = out_valid & out_ready.
REQ-016 out_valid SHALL be 1 in ONE and FULL; out_data SHALL equal the main register.
REQ-017 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, and SHALL be derived from state only (no combinational path from out_ready or in_valid).
REQ-018 EMPTY: accept -> ONE, main<=in_data.
REQ-019 ONE: accept&consume -> ONE, main<=in_data; consume only -> EMPTY; accept only -> FULL, skid<=in_data; neither -> ONE.
REQ-020 FULL: consume -> ONE, main<=skid; otherwise hold.
REQ-021 Latency SHALL be 1 cycle from accept to out_valid; sustained throughput SHALL be 1 entry/cycle when out_ready=1.
REQ-022 Ordering SHALL be strict FIFO; no entry SHALL be lost or duplicated without flush.
REQ-023 On entry to EMPTY by drain, the main register SHALL retain its last value.
REQ-024 flush=1 SHALL force next state EMPTY, zero the main and skid registers, and discard any in_data offered that cycle, regardless of out_ready.
REQ-025 startin SHALL take priority over flush; flush SHALL take priority over all transfers.

Reset
REQ-026 With startin=1 at a rising edge, the next state SHALL be: state EMPTY, main=0, skid=0, out_valid=0, in_ready=1, stall_cnt=0, flush_cnt=0.
REQ-027 Reset asserted mid-operation in any state SHALL yield the values in REQ-026 on the next cycle; in-flight entries are dropped.

Configuration
REQ-028 Macro PIPE_STAGE_PERF_EN: when defined, the counters below SHALL be implemented.
REQ-029 stall_cnt SHALL increment in each cycle with out_valid=1, out_ready=0, flush=0 and startin=0.
REQ-030 flush_cnt SHALL increment in each cycle with flush=1, out_valid=1 and startin=0.
REQ-031 Both counters SHALL saturate at 2^CNT_W-1.
REQ-032 When PIPE_STAGE_PERF_EN is undefined, stall_cnt and flush_cnt SHALL be constant 0, ports SHALL remain present, and datapath behaviour SHALL be identical.

Verification
REQ-033 Streaming: reset, out_ready=1, in_valid=1 with data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later, out_valid high 4 cycles, in_ready constantly 1.
REQ-034 Skid: stage holds A, out_ready=0, offer B -> state FULL, in_ready=0; offer C is not accepted.
REQ-035 Skid drain: continuing REQ-034, out_ready=1 -> outputs A then B on consecutive cycles, and C is accepted when in_ready returns to 1.
REQ-036 Flush: flush in FULL with in_valid=1, data D -> next cycle out_valid=0, out_data=0, in_ready=1, D never appears, flush_cnt=1 (macro on).
REQ-037 Priority: startin=1 and flush=1 together in state ONE -> all REQ-026 reset values, flush_cnt stays 0.
REQ-038 Saturation: CNT_W=4, macro on, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 and holds; with macro off, stall_cnt stays 0 throughout.
